// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: adds two LIMBS*W-bit operands one W-bit limb per clock,
// LSB limb first, through a shared external ripple-adder slice. The slice carry
// is chained between limbs through an internal carry register.
//
// Optional feature: define MULTIWORD_ADDER_SEQ_SUB_EN to add the `op` input
// (op=1 computes A - B as A + ~B + 1; cout=1 then means no borrow).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse, sampled only in IDLE
//   op                  (SUB_EN only) 1 = subtract, latched on start
//   a, b, cin           operands and carry-in, latched on start
//   busy, done          handshake: busy while limbs run, done one-cycle pulse
//   sum, cout           result register and final carry-out register
//   add_a/add_b/add_cin limb operands and carry driven to the slice
//   add_sum/add_cout    slice result, combinational from add_a/add_b/add_cin
module multiword_adder_seq #(
    parameter int unsigned W     = 5,
    parameter int unsigned LIMBS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
    input  logic                 op,
`endif
    input  logic [W*LIMBS-1:0]   a,
    input  logic [W*LIMBS-1:0]   b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [W*LIMBS-1:0]   sum,
    output logic                 cout,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_cin,
    input  logic [W-1:0]         add_sum,
    input  logic                 add_cout
);

    localparam int unsigned IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         carry_q, carry_d;
    logic [LIMBS-1:0][W-1:0]      a_q, a_d;
    logic [LIMBS-1:0][W-1:0]      b_q, b_d;
    logic [LIMBS-1:0][W-1:0]      sum_q, sum_d;
    logic                         cout_q, cout_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    // Values loaded into the B and carry registers on an accepted start.
    logic [W*LIMBS-1:0]           b_load_c;
    logic                         carry_load_c;

`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
    // Subtraction stores ~B and forces the initial carry to 1.
    assign b_load_c     = op ? ~b : b;
    assign carry_load_c = op ? 1'b1 : cin;
`else
    assign b_load_c     = b;
    assign carry_load_c = cin;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load_c;
                    carry_d = carry_load_c;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Slice drive comes only from registered operands; idle slice sees zeros.
    assign add_a   = (state_q == RUN) ? a_q[idx_q] : '0;
    assign add_b   = (state_q == RUN) ? b_q[idx_q] : '0;
    assign add_cin = (state_q == RUN) ? carry_q : 1'b0;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// tb_multiword_adder_seq: randomized and directed checks of multiword_adder_seq
// against an arithmetic reference model, with a behavioural adder slice.
module tb_multiword_adder_seq;

    localparam int unsigned W     = 5;
    localparam int unsigned LIMBS = 4;
    localparam int unsigned N     = W * LIMBS;

    logic           clk;
    logic           rst_n;
    logic           start;
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
    logic           op;
`endif
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [N-1:0]   sum;
    logic           cout;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    int n_cmp = 0;
    int n_err = 0;

    multiword_adder_seq #(.W(W), .LIMBS(LIMBS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
        .op       (op),
`endif
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External W-bit slice.
    assign {add_cout, add_sum} = (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full-width arithmetic on the effective operands.
    function automatic logic [63:0] eff_b(input logic [N-1:0] xb, input logic xop);
        logic [63:0] m;
        m = (64'd1 << N) - 64'd1;
        return xop ? (~64'(xb)) & m : 64'(xb);
    endfunction

    function automatic logic [63:0] ref_result(input logic [N-1:0] xa, input logic [N-1:0] xb,
                                               input logic xc, input logic xop);
        logic [63:0] c0;
        c0 = xop ? 64'd1 : 64'(xc);
        return 64'(xa) + eff_b(xb, xop) + c0;
    endfunction

    // Carry entering limb i = carry out of the low i*W bits of the same sum.
    function automatic logic ref_carry_in(input logic [N-1:0] xa, input logic [N-1:0] xb,
                                          input logic xc, input logic xop, input int i);
        logic [63:0] m, c0, s;
        m  = (64'd1 << (i * W)) - 64'd1;
        c0 = xop ? 64'd1 : 64'(xc);
        s  = (64'(xa) & m) + (eff_b(xb, xop) & m) + c0;
        return s[i * W];
    endfunction

    function automatic logic [63:0] limb(input logic [63:0] v, input int i);
        return (v >> (i * W)) & ((64'd1 << W) - 64'd1);
    endfunction

    // One full operation; optionally re-pulses start and disturbs a/b/cin mid-run.
    task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc,
                          input logic xop, input bit disturb);
        logic [63:0] exp;
        exp = ref_result(xa, xb, xc, xop);
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
        op = xop;
`endif
        for (int i = 0; i < int'(LIMBS); i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (disturb && i == 1) begin
                start = 1'b1; a = 20'h12345; b = 20'h11111; cin = ~xc;
            end
            if (disturb && i == 2) start = 1'b0;
            check($sformatf("busy_run%0d", i), 64'(busy), 64'd1);
            check($sformatf("add_a%0d", i), 64'(add_a), limb(64'(xa), i));
            check($sformatf("add_b%0d", i), 64'(add_b), limb(eff_b(xb, xop), i));
            check($sformatf("add_cin%0d", i), 64'(add_cin), 64'(ref_carry_in(xa, xb, xc, xop, i)));
        end
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("sum", 64'(sum), exp & ((64'd1 << N) - 64'd1));
        check("cout", 64'(cout), 64'(exp[N]));
        check("add_a_done", 64'(add_a), 64'd0);
        @(negedge clk);
        check("done_low", 64'(done), 64'd0);
        check("sum_hold", 64'(sum), exp & ((64'd1 << N) - 64'd1));
    endtask

    initial begin
        int t1, t2, cyc, ndone;
        logic [63:0] exp;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
        op = 1'b0;
`endif
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(20'h00015, 20'h00012, 1'b0, 1'b0, 1'b0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 1'b0);
        run_op(20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0, 1'b0);
        run_op(20'h00001, 20'h00001, 1'b0, 1'b0, 1'b0);
        run_op(20'h0ABCD, 20'h54321, 1'b1, 1'b0, 1'b1);

        // Randomized operations.
        for (int k = 0; k < 20; k++) begin
            logic xop;
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
            xop = 1'($urandom_range(0, 1));
`else
            xop = 1'b0;
`endif
            run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), xop, (k % 4) == 3);
        end

`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
        run_op(20'h00010, 20'h00011, 1'b0, 1'b1, 1'b0);
        run_op(20'h00011, 20'h00010, 1'b1, 1'b1, 1'b0);
`endif

        // Start held high: back-to-back operations LIMBS+2 cycles apart.
        @(negedge clk);
        a = N'($urandom); b = N'($urandom); cin = 1'b1; start = 1'b1;
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
        op = 1'b0;
`endif
        exp = ref_result(a, b, cin, 1'b0);
        t1 = -1; t2 = -1;
        for (cyc = 0; cyc < 40 && t2 < 0; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    check("held_sum", 64'(sum), exp & ((64'd1 << N) - 64'd1));
                    check("held_cout", 64'(cout), 64'(exp[N]));
                end else begin
                    t2 = cyc;
                end
            end
        end
        check("held_timeout", 64'(t2 < 0), 64'd0);
        check("held_spacing", 64'(t2 - t1), 64'(LIMBS + 2));
        start = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset mid-operation.
        @(negedge clk);
        a = 20'h13579; b = 20'h2468A; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        check("mid_rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_rst", 64'(ndone), 64'd0);
        run_op(20'h13579, 20'h2468A, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiword_adder_seq.md
Name: multiword_adder_seq

Overview:
- Multi-cycle controller that adds two wide operands using one external W-bit ripple adder slice (the team's five_bit_adder when W=5).
- Processes one limb per clock, LSB limb first, and chains the slice carry through an internal carry register.
- Owns the operand/result registers and a start/busy/done handshake; sits between a requesting unit and the shared adder slice.

Parameters:
- W, 5, width of one adder slice/limb in bits.
- LIMBS, 4, number of limbs per operand; N = W*LIMBS (20 by default); LIMBS >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  N  operand A; latched on accepted start.
- b  input  N  operand B; latched on accepted start.
- cin  input  1  initial carry-in; latched on accepted start.
- busy  output  1  high while limbs are being processed.
- done  output  1  one-cycle completion pulse.
- sum  output  N  result register.
- cout  output  1  final carry-out register.
- add_a  output  W  limb of A driven to the slice.
- add_b  output  W  limb of B driven to the slice.
- add_cin  output  1  carry driven to the slice.
- add_sum  input  W  slice sum, combinational from add_a/add_b/add_cin.
- add_cout  input  1  slice carry-out.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, idx=0, carry=0, operand regs=0, sum=0, cout=0, busy=0, done=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On an edge with start=1: latch a, b, cin (cin goes into the carry register); clear sum and cout to 0; set idx=0; go to RUN.
  - With start=0: stay in IDLE; sum and cout hold their values.
- RUN:
  - busy=1.
  - add_a = A[idx*W +: W]; add_b = B[idx*W +: W]; add_cin = carry. All three come from registers, not from the a/b/cin ports.
  - Each edge: sum[idx*W +: W] <= add_sum; carry <= add_cout; idx <= idx+1.
  - On the edge where idx = LIMBS-1: also cout <= add_cout; go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; then go to IDLE unconditionally.
- Slice drive outside RUN: add_a, add_b and add_cin are driven to 0 in IDLE and DONE.
- Latency: start accepted on edge k → result complete and DONE entered on edge k+LIMBS → done high during cycle k+LIMBS to k+LIMBS+1. Throughput is one operation per LIMBS+2 cycles.
- start while busy or done is high: ignored, with no queueing and no side effects.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- a, b, cin changing during RUN: no effect on the result.
- Arithmetic: {cout, sum} = A + B + cin, modulo 2^(N+1). There is no overflow flag.
- Reset asserted mid-RUN: immediate return to reset values. The partial result is discarded and no done pulse is issued.

Optional Feature:
- Macro MULTIWORD_ADDER_SEQ_SUB_EN.
- When defined:
  - Adds input port op (1 bit), latched with the operands on start.
  - op=1 computes A - B as A + ~B + 1: B is stored inverted and the carry register is loaded with 1, ignoring cin.
  - cout=1 means no borrow (A >= B).
  - op=0 behaves as plain addition.
- When undefined: no op port; addition only; no inverter logic.

Test Plan:
- Basic add: a=0x00015, b=0x00012, cin=0, start pulse → busy for 4 cycles, done at cycle 5, sum=0x00027, cout=0; add_a sequence 0x15, 0x00, 0x00, 0x00.
- Full carry ripple: a=0xFFFFF, b=0x00001, cin=0 → add_cin sequence 0,1,1,1; sum=0x00000, cout=1.
- Max with carry-in: a=b=0xFFFFF, cin=1 → sum=0xFFFFF, cout=1. The next op, a=0x00001, b=0x00001, cin=0, must give sum=0x00002, cout=0 (carry register correctly reloaded).
- Handshake:
  - start re-pulsed while busy with a=0x12345, b=0x11111 → ignored; the in-flight result is unchanged.
  - Changing a/b during RUN → no effect on the result.
  - start held high → back-to-back ops separated by exactly LIMBS+2 cycles.
- Reset mid-op: drop rst_n after 2 RUN cycles → asynchronously busy=0, done=0, sum=0, cout=0, add_* = 0; no done pulse follows; a fresh op afterwards is correct.
- With MULTIWORD_ADDER_SEQ_SUB_EN:
  - op=1, a=0x00010, b=0x00011 → sum=0xFFFFF, cout=0.
  - op=1, a=0x00011, b=0x00010 → sum=0x00001, cout=1.
